uart_mmio: RTL and testbench

UART_MMIO -- requirements
Module: uart_mmio

---
 rtl/uart_mmio.sv | 146 ++++++++++++++
 tb/tb_uart_mmio.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped UART transmitter with TX FIFO, baud divider and low-water irq.
// Define UART_MMIO_PARITY_EN to build the CTRL parity bits and the PARITY state.
module uart_mmio #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int IRQ_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  we,
    input  logic                  oe,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_wr,
    output logic [DATA_WIDTH-1:0] data_rd,
    output logic                  tx,
    output logic                  irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef UART_MMIO_PARITY_EN
    localparam logic [DATA_WIDTH-1:0] CTRL_MASK = DATA_WIDTH'(9'h1ff);
`else
    localparam logic [DATA_WIDTH-1:0] CTRL_MASK = DATA_WIDTH'(9'h1f3);
`endif
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_MMIO_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;
    state_t state, state_n;
    logic [DATA_WIDTH-1:0] ctrl, clk_div, div_eff, cnt, status, rd_val;
    logic [15:0] mem [FIFO_DEPTH];
    logic [15:0] sh;
    logic [AW-1:0] wptr, rptr;
    logic [8:0] level;
    logic [4:0] bpw, nbits, bit_cnt;
    logic wr_q, rd_q, wr_prev, push, push_ok, pop, full, empty, ovf, busy, tick, last;
    logic soft_rst, tx_en, par;
    assign wr_q = !cs && !we && oe;
    assign rd_q = !cs && we && !oe;
    assign push = wr_q && !wr_prev && address == ADDR_WIDTH'(3);
    assign soft_rst = ctrl[0];
    assign tx_en = ctrl[1];
    assign bpw = ctrl[8:4];
    assign nbits = (bpw == 5'd0 || bpw > 5'd16) ? 5'd16 : bpw;
    assign full = level == 9'(FIFO_DEPTH);
    assign empty = level == '0;
    assign push_ok = push && !full;
    assign busy = state != IDLE;
    assign div_eff = clk_div == '0 ? DATA_WIDTH'(1) : clk_div;
    assign tick = busy && cnt >= div_eff - DATA_WIDTH'(1);
    assign last = bit_cnt == nbits - 5'd1;
    assign status = DATA_WIDTH'({ovf, busy, empty, full, level});
    assign rd_val = address == ADDR_WIDTH'(0) ? ctrl :
                    address == ADDR_WIDTH'(1) ? status :
                    address == ADDR_WIDTH'(2) ? clk_div : '0;
    assign irq = tx_en && (32'(level) <= IRQ_THRESH);
    assign tx = state == START ? 1'b0 :
                state == DATA ? sh[0] :
`ifdef UART_MMIO_PARITY_EN
                state == PARITY ? par :
`endif
                1'b1;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ctrl <= DATA_WIDTH'(16'h0081);
            clk_div <= DATA_WIDTH'(1);
            wr_prev <= 1'b0;
            data_rd <= '0;
        end else begin
            wr_prev <= wr_q;
            data_rd <= rd_q ? rd_val : '0;
            if (wr_q && address == ADDR_WIDTH'(0)) ctrl <= data_wr & CTRL_MASK;
            if (wr_q && address == ADDR_WIDTH'(2)) clk_div <= data_wr;
        end

    always_ff @(posedge clk)
        if (push_ok) mem[wptr] <= data_wr[15:0];

    // A push that finds the FIFO full wins over a same-cycle STATUS read clearing overflow.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            level <= '0;
            ovf <= 1'b0;
        end else if (soft_rst) begin
            wptr <= '0;
            rptr <= '0;
            level <= '0;
            ovf <= 1'b0;
        end else begin
            if (push_ok) wptr <= wptr + AW'(1);
            if (pop) rptr <= rptr + AW'(1);
            level <= level + 9'(push_ok) - 9'(pop);
            ovf <= (push && full) ? 1'b1 : (rd_q && address == ADDR_WIDTH'(1)) ? 1'b0 : ovf;
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            bit_cnt <= '0;
            sh <= '0;
            par <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= (tick || !busy) ? '0 : cnt + DATA_WIDTH'(1);
            bit_cnt <= pop ? 5'd0 : (state == DATA && tick) ? bit_cnt + 5'd1 : bit_cnt;
            sh <= pop ? mem[rptr] : (state == DATA && tick) ? sh >> 1 : sh;
            par <= pop ? ctrl[3] : (state == DATA && tick) ? par ^ sh[0] : par;
        end

    always_comb begin
        state_n = state;
        pop = 1'b0;
        case (state)
            IDLE: if (tx_en && !empty) begin
                state_n = START;
                pop = 1'b1;
            end
            START: if (tick) state_n = DATA;
`ifdef UART_MMIO_PARITY_EN
            DATA: if (tick && last) state_n = ctrl[2] ? PARITY : STOP;
            PARITY: if (tick) state_n = STOP;
`else
            DATA: if (tick && last) state_n = STOP;
`endif
            STOP: if (tick) begin
                state_n = (tx_en && !empty) ? START : IDLE;
                pop = tx_en && !empty;
            end
            default: state_n = IDLE;
        endcase
        if (soft_rst) begin
            state_n = IDLE;
            pop = 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: directed register-vector table plus hand-written frame, overflow and reset sequences.
module tb_uart_mmio;
    logic clk = 1'b0, rst = 1'b1, cs = 1'b1, we = 1'b1, oe = 1'b1, tx, irq;
    logic [4:0] address = '0;
    logic [15:0] data_wr = '0, data_rd;
    int vecs = 0, errs = 0;
    typedef struct {
        bit          wr;
        logic [4:0]  a;
        logic [15:0] d;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl [$];
`ifdef UART_MMIO_PARITY_EN
    localparam logic [15:0] CTRL_ALL = 16'h01ff;
`else
    localparam logic [15:0] CTRL_ALL = 16'h01f3;
`endif

    uart_mmio dut (
        .clk(clk), .rst(rst), .cs(cs), .we(we), .oe(oe), .address(address),
        .data_wr(data_wr), .data_rd(data_rd), .tx(tx), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic bus_wr(input logic [4:0] a, input logic [15:0] d, input int hold = 1);
        @(negedge clk);
        cs = 1'b0; we = 1'b0; oe = 1'b1; address = a; data_wr = d;
        repeat (hold) @(negedge clk);
        cs = 1'b1; we = 1'b1;
    endtask

    task automatic bus_rd(input logic [4:0] a, output logic [15:0] d);
        @(negedge clk);
        cs = 1'b0; we = 1'b1; oe = 1'b0; address = a;
        @(negedge clk);
        d = data_rd;
        cs = 1'b1; oe = 1'b1;
    endtask

    task automatic rd_chk(input string name, input logic [4:0] a, input logic [15:0] exp);
        logic [15:0] d;
        bus_rd(a, d);
        check(name, 32'(d), 32'(exp));
    endtask

    // Leaves the bench on the first negedge of the START bit.
    task automatic wait_start(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = !tx;
        end
        if (!ok) check({name, " start timeout"}, 32'(tx), 32'(0));
    endtask

    // pat bit k is the expected line level during frame bit k (bit 0 = START).
    task automatic check_frame(input string name, input int nb, input logic [31:0] pat, input int div);
        bit ok;
        wait_start(name, ok);
        if (!ok) return;
        for (int k = 0; k < nb; k++)
            for (int c = 0; c < div; c++) begin
                if (k != 0 || c != 0) @(negedge clk);
                check($sformatf("%s bit%0d cyc%0d", name, k, c), 32'(tx), 32'(pat[k]));
            end
    endtask

    initial begin
        logic [15:0] d;
        bit ok;
        tbl.push_back('{1'b0, 5'd0, 16'h0000, 16'h0081});
        tbl.push_back('{1'b0, 5'd1, 16'h0000, 16'h0400});
        tbl.push_back('{1'b1, 5'd2, 16'h0004, 16'h0000});
        tbl.push_back('{1'b0, 5'd2, 16'h0000, 16'h0004});
        tbl.push_back('{1'b1, 5'd0, 16'hffff, 16'h0000});
        tbl.push_back('{1'b0, 5'd0, 16'h0000, CTRL_ALL});
        tbl.push_back('{1'b1, 5'd5, 16'h1234, 16'h0000});
        tbl.push_back('{1'b0, 5'd5, 16'h0000, 16'h0000});
        tbl.push_back('{1'b0, 5'd3, 16'h0000, 16'h0000});
        tbl.push_back('{1'b1, 5'd1, 16'hffff, 16'h0000});
        tbl.push_back('{1'b0, 5'd1, 16'h0000, 16'h0400});
        tbl.push_back('{1'b1, 5'd0, 16'h0080, 16'h0000});
        tbl.push_back('{1'b1, 5'd3, 16'h0011, 16'h0000});
        tbl.push_back('{1'b1, 5'd3, 16'h0022, 16'h0000});
        tbl.push_back('{1'b0, 5'd1, 16'h0000, 16'h0002});
        tbl.push_back('{1'b0, 5'd0, 16'h0000, 16'h0080});
        tbl.push_back('{1'b1, 5'd0, 16'h0081, 16'h0000});
        tbl.push_back('{1'b0, 5'd1, 16'h0000, 16'h0400});
        tbl.push_back('{1'b0, 5'd2, 16'h0000, 16'h0004});
        repeat (2) @(negedge clk);
        check("rst tx", 32'(tx), 32'(1));
        check("rst irq", 32'(irq), 32'(0));
        check("rst data_rd", 32'(data_rd), 32'(0));
        rst = 1'b0;
        foreach (tbl[i])
            if (tbl[i].wr) bus_wr(tbl[i].a, tbl[i].d);
            else rd_chk($sformatf("vec%0d", i), tbl[i].a, tbl[i].exp);
        @(negedge clk);
        check("data_rd idle", 32'(data_rd), 32'(0));
        // Held write pushes once; then overflow the 16-entry FIFO.
        bus_wr(5'd0, 16'h0080);
        bus_wr(5'd3, 16'h0099, 3);
        rd_chk("held push", 5'd1, 16'h0001);
        for (int i = 0; i < 16; i++) bus_wr(5'd3, 16'(i));
        check("irq tx_en=0", 32'(irq), 32'(0));
        rd_chk("overflow status", 5'd1, 16'h1210);
        rd_chk("overflow cleared", 5'd1, 16'h0210);
        bus_wr(5'd0, 16'h0081);
        rd_chk("flush", 5'd1, 16'h0400);
        // 8-bit frame at CLK_DIV=4.
        bus_wr(5'd0, 16'h0082);
        bus_wr(5'd3, 16'h0055);
        check_frame("f55", 10, 32'({1'b1, 8'h55, 1'b0}), 4);
        rd_chk("idle after frame", 5'd1, 16'h0400);
        check("irq low level", 32'(irq), 32'(1));
        // 16-bit frame (bits_per_word=0), back-to-back frames and irq low-water.
        bus_wr(5'd0, 16'h0000);
        bus_wr(5'd2, 16'h0002);
        bus_wr(5'd3, 16'ha5c3);
        bus_wr(5'd3, 16'h1111);
        bus_wr(5'd3, 16'h2222);
        bus_wr(5'd3, 16'h3333);
        check("irq disabled", 32'(irq), 32'(0));
        bus_wr(5'd0, 16'h0002);
        check_frame("fa5c3", 18, 32'({1'b1, 16'ha5c3, 1'b0}), 2);
        check("irq level3", 32'(irq), 32'(0));
        @(negedge clk);
        check("b2b start", 32'(tx), 32'(0));
        check("irq level2", 32'(irq), 32'(1));
        bus_wr(5'd0, 16'h0001);
        @(negedge clk);
        check("soft_rst tx", 32'(tx), 32'(1));
        rd_chk("soft_rst status", 5'd1, 16'h0400);
`ifdef UART_MMIO_PARITY_EN
        bus_wr(5'd0, 16'h008e);
        bus_wr(5'd3, 16'h0007);
        check_frame("fpar", 11, 32'({1'b1, 1'b0, 8'h07, 1'b0}), 2);
        bus_wr(5'd0, 16'h0081);
`endif
        // Asynchronous reset in the middle of a data bit.
        bus_wr(5'd0, 16'h0082);
        bus_wr(5'd2, 16'h0004);
        bus_wr(5'd3, 16'h00fe);
        wait_start("frst", ok);
        repeat (6) @(negedge clk);
        check("pre-rst data bit", 32'(tx), 32'(0));
        rst = 1'b1;
        #1;
        check("rst mid-frame tx", 32'(tx), 32'(1));
        check("rst mid-frame irq", 32'(irq), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        rd_chk("post-rst status", 5'd1, 16'h0400);
        rd_chk("post-rst ctrl", 5'd0, 16'h0081);
        rd_chk("post-rst clk_div", 5'd2, 16'h0001);
        bus_rd(5'd1, d);
        check("post-rst tx", 32'(tx), 32'(1));
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
